uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have port clk, input, 1 bit: system clock, all logic on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port rxd, input, 1 bit: asynchronous serial line, idle high.
REQ-004 SHALL have port prescale, input, 16 bits: bit period equals prescale*8 clk cycles.
REQ-005 SHALL have port m_axis_tdata, output, 8 bits: received byte.
REQ-006 SHALL have port m_axis_tvalid, output, 1 bit: byte available.
REQ-007 SHALL have port m_axis_tready, input, 1 bit: consumer accepts the byte.
REQ-008 SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-009 SHALL have port overrun_error, output, 1 bit: one-cycle pulse when a byte completes while m_axis_tvalid is high.
REQ-010 SHALL have port frame_error, output, 1 bit: one-cycle pulse when the stop bit samples low.

Function
REQ-011 SHALL pass rxd through a 2-flop synchronizer; rxd_s names the synchronized value, and all decisions use rxd_s.
REQ-012 SHALL implement states IDLE, START, DATA, STOP and BREAK, with a 19-bit down-counter and a 4-bit bit counter.
REQ-013 SHALL treat the sample point of a state as the cycle in which the counter equals 0.
REQ-014 In IDLE with prescale != 0 and rxd_s == 0, SHALL latch prescale, load the counter with (prescale<<2)-1 and enter START.
REQ-015 With prescale == 0, SHALL remain in IDLE and ignore rxd.
REQ-016 At the START sample point with the sampled value 0, SHALL load (prescale<<3)-1, set the bit counter to 8 and enter DATA.
REQ-017 At the START sample point with the sampled value 1, SHALL return to IDLE, discarding the glitch with no output and no error.
REQ-018 At each DATA sample point, SHALL shift the sampled value in LSB-first, decrement the bit counter and reload (prescale<<3)-1.
REQ-019 After the 8th bit, SHALL enter STOP.
REQ-020 At the STOP sample point with the sampled value 1, SHALL drive m_axis_tdata with the byte and set m_axis_tvalid the next cycle, then go to IDLE.
REQ-021 At the STOP sample point with the sampled value 0, SHALL pulse frame_error, discard the byte and enter BREAK.
REQ-022 In BREAK, SHALL wait until rxd_s == 1, then go to IDLE.
REQ-023 SHALL use the prescale value latched at start detection; changes to prescale mid-frame have no effect.
REQ-024 m_axis_tvalid SHALL stay high until a cycle with m_axis_tready == 1, then clear the next cycle.
REQ-025 m_axis_tdata SHALL be stable while m_axis_tvalid is high, except on overrun.
REQ-026 On overrun (a new byte completes while m_axis_tvalid is high and m_axis_tready is low), SHALL overwrite m_axis_tdata with the new byte, keep m_axis_tvalid high and pulse overrun_error.
REQ-027 If m_axis_tready is high in the same cycle a new byte completes, SHALL count the old byte as accepted, load the new byte, keep m_axis_tvalid high and raise no overrun.
REQ-028 busy SHALL be high in START, DATA, STOP and BREAK, and low in IDLE.
REQ-029 Reception SHALL continue regardless of m_axis_tready; the block applies no backpressure.

Reset
REQ-030 On rst, SHALL go to IDLE, clear both counters and the shift register, set m_axis_tdata=0, m_axis_tvalid=0, busy=0, overrun_error=0, frame_error=0, and set the synchronizer flops to 1.
REQ-031 rst asserted mid-frame SHALL abandon the frame with no output or error pulse; after release, SHALL wait for a fresh falling edge of rxd_s.

Configuration
REQ-032 With macro UART_RX_MAJORITY_EN defined, the sampled value at every sample point SHALL be the 2-of-3 majority of rxd_s over the sample cycle and the two preceding cycles.
REQ-033 Without UART_RX_MAJORITY_EN, the sampled value SHALL be the single rxd_s value at the sample cycle; timing is identical in both builds.

Verification
REQ-034 prescale=1, send frame 0x55 detected at cycle T -> m_axis_tvalid=1 at T+76 with m_axis_tdata=0x55, no error pulses.
REQ-035 prescale=4, back-to-back frames 0xA3, 0x0F with tready=1 -> two single-cycle tvalid beats, data 0xA3 then 0x0F, busy low only between frames.
REQ-036 rxd low pulse of 2 cycles at prescale=2 -> no tvalid, no error, busy drops at the START sample point.
REQ-037 Frame 0x3C with stop bit forced 0 -> frame_error single pulse, tvalid stays 0, busy held until rxd returns high.
REQ-038 tready=0, frames 0x11 then 0x22 -> overrun_error pulse at second completion, tdata=0x22, tvalid=1 until tready rises.
REQ-039 rst asserted during bit 4 of frame 0xFF -> all outputs 0 next cycle, no output for that frame; next clean 0x81 received correctly.

Source files
------------

// File: rtl/uart_rx_if.sv
// Byte-stream handshake from the UART receiver to its consumer.
interface uart_rx_if;
   logic [7:0] m_axis_tdata;
   logic       m_axis_tvalid;
   logic       m_axis_tready;

   modport master (output m_axis_tdata, output m_axis_tvalid, input m_axis_tready);
   modport slave  (input m_axis_tdata, input m_axis_tvalid, output m_axis_tready);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 2-flop synchronizer and an AXI-stream style byte output.
// Define UART_RX_MAJORITY_EN to take each sample as a 2-of-3 vote over the last three rxd_s values.
module uart_rx (
   input  logic        clk,
   input  logic        rst,
   input  logic        rxd,
   input  logic [15:0] prescale,
   uart_rx_if.master   m_axis,
   output logic        busy,
   output logic        overrun_error,
   output logic        frame_error
);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

   state_t      state_q, state_d;
   logic        sync1_q, sync2_q;
   logic [15:0] presc_q, presc_d;
   logic [18:0] cnt_q, cnt_d;
   logic [3:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  tdata_q, tdata_d;
   logic        tvalid_q, tvalid_d;
   logic        busy_q, busy_d;
   logic        overrun_q, overrun_d;
   logic        frame_err_q, frame_err_d;
   logic        rxd_s;
   logic        samp;
   logic [18:0] bit_reload;

   assign rxd_s      = sync2_q;
   assign bit_reload = ({3'b000, presc_q} << 3) - 19'd1;

`ifdef UART_RX_MAJORITY_EN
   logic hist1_q, hist2_q;
   assign samp = (rxd_s & hist1_q) | (rxd_s & hist2_q) | (hist1_q & hist2_q);
`else
   assign samp = rxd_s;
`endif

   always_comb begin
      state_d     = state_q;
      presc_d     = presc_q;
      cnt_d       = cnt_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      tdata_d     = tdata_q;
      tvalid_d    = tvalid_q;
      busy_d      = busy_q;
      overrun_d   = 1'b0;
      frame_err_d = 1'b0;

      if (m_axis.m_axis_tready)
         tvalid_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (prescale != 16'd0 && !rxd_s) begin
               presc_d = prescale;
               cnt_d   = ({3'b000, prescale} << 2) - 19'd1;
               state_d = START;
               busy_d  = 1'b1;
            end
         end
         START: begin
            if (cnt_q == 19'd0) begin
               if (!samp) begin
                  cnt_d     = bit_reload;
                  bit_cnt_d = 4'd8;
                  state_d   = DATA;
               end else begin
                  // Start bit did not hold to mid-bit: treat as line noise.
                  state_d = IDLE;
                  busy_d  = 1'b0;
               end
            end else begin
               cnt_d = cnt_q - 19'd1;
            end
         end
         DATA: begin
            if (cnt_q == 19'd0) begin
               shift_d   = {samp, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q - 4'd1;
               cnt_d     = bit_reload;
               if (bit_cnt_q == 4'd1)
                  state_d = STOP;
            end else begin
               cnt_d = cnt_q - 19'd1;
            end
         end
         STOP: begin
            if (cnt_q == 19'd0) begin
               if (samp) begin
                  // A pending unaccepted byte is overwritten; ready this cycle counts as accepted.
                  tdata_d   = shift_q;
                  tvalid_d  = 1'b1;
                  overrun_d = tvalid_q && !m_axis.m_axis_tready;
                  state_d   = IDLE;
                  busy_d    = 1'b0;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = BREAK;
               end
            end else begin
               cnt_d = cnt_q - 19'd1;
            end
         end
         BREAK: begin
            if (rxd_s) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         state_q     <= IDLE;
         presc_q     <= 16'd0;
         cnt_q       <= 19'd0;
         bit_cnt_q   <= 4'd0;
         shift_q     <= 8'd0;
         tdata_q     <= 8'd0;
         tvalid_q    <= 1'b0;
         busy_q      <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         sync1_q     <= rxd;
         sync2_q     <= sync1_q;
         state_q     <= state_d;
         presc_q     <= presc_d;
         cnt_q       <= cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         tdata_q     <= tdata_d;
         tvalid_q    <= tvalid_d;
         busy_q      <= busy_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
      end
   end

`ifdef UART_RX_MAJORITY_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         hist1_q <= 1'b1;
         hist2_q <= 1'b1;
      end else begin
         hist1_q <= rxd_s;
         hist2_q <= hist1_q;
      end
   end
`endif

   assign m_axis.m_axis_tdata  = tdata_q;
   assign m_axis.m_axis_tvalid = tvalid_q;
   assign busy                 = busy_q;
   assign overrun_error        = overrun_q;
   assign frame_error          = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected bytes, a monitor pops them on each new output beat.
module tb_uart_rx;

   logic        clk;
   logic        rst;
   logic        rxd;
   logic [15:0] prescale;
   logic        busy;
   logic        overrun_error;
   logic        frame_error;

   uart_rx_if axis ();

   uart_rx dut (
      .clk           (clk),
      .rst           (rst),
      .rxd           (rxd),
      .prescale      (prescale),
      .m_axis        (axis),
      .busy          (busy),
      .overrun_error (overrun_error),
      .frame_error   (frame_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   logic [7:0] exp_q[$];
   int cyc = 0;
   int busy_rise_cyc = 0;
   int vld_cyc = 0;
   int busy_rises = 0;
   int busy_hi = 0;
   int vld_hi = 0;
   int vld_events = 0;
   int fe_cnt = 0;
   int ov_cnt = 0;
   bit prev_vld = 1'b0;
   bit prev_busy = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: samples just after each rising edge, so tready read here is what the edge saw.
   always @(posedge clk) begin
      #1;
      cyc++;
      if (rst) begin
         prev_vld  = 1'b0;
         prev_busy = 1'b0;
      end else begin
         if (busy && !prev_busy) begin
            busy_rises++;
            busy_rise_cyc = cyc;
         end
         if (busy)          busy_hi++;
         if (axis.m_axis_tvalid) vld_hi++;
         if (frame_error)   fe_cnt++;
         if (overrun_error) ov_cnt++;
         if (axis.m_axis_tvalid && (!prev_vld || axis.m_axis_tready || overrun_error)) begin
            vld_events++;
            vld_cyc = cyc;
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_byte: got 0x%0h expected no output", axis.m_axis_tdata);
            end else begin
               check("rx_byte", {24'd0, axis.m_axis_tdata}, {24'd0, exp_q.pop_front()});
            end
         end
         prev_vld  = axis.m_axis_tvalid;
         prev_busy = busy;
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input int bp, input bit stop_val);
      rxd = 1'b0;
      wait_cyc(bp);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         wait_cyc(bp);
      end
      rxd = stop_val;
      wait_cyc(bp);
   endtask

   int ev0, fe0, ov0, bh0, vh0, br0;

   task automatic snap();
      ev0 = vld_events; fe0 = fe_cnt; ov0 = ov_cnt;
      bh0 = busy_hi;    vh0 = vld_hi; br0 = busy_rises;
   endtask

   initial begin
      rst = 1'b1;
      rxd = 1'b1;
      prescale = 16'd1;
      axis.m_axis_tready = 1'b1;
      wait_cyc(4);
      check("rst_tvalid", {31'd0, axis.m_axis_tvalid}, 32'd0);
      check("rst_tdata", {24'd0, axis.m_axis_tdata}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_errs", {30'd0, overrun_error, frame_error}, 32'd0);
      rst = 1'b0;
      wait_cyc(4);

      // 0x55 at prescale 1; prescale changed mid-frame must not disturb timing.
      snap();
      exp_q.push_back(8'h55);
      fork
         send_frame(8'h55, 8, 1'b1);
         begin wait_cyc(20); prescale = 16'd6; end
      join
      wait_cyc(10);
      prescale = 16'd1;
      check("p1_events", vld_events - ev0, 1);
      check("p1_latency", vld_cyc - busy_rise_cyc, 76);
      check("p1_errors", (fe_cnt - fe0) + (ov_cnt - ov0), 0);

      // Back-to-back frames at prescale 4 with tready high.
      prescale = 16'd4;
      snap();
      exp_q.push_back(8'hA3);
      exp_q.push_back(8'h0F);
      send_frame(8'hA3, 32, 1'b1);
      send_frame(8'h0F, 32, 1'b1);
      wait_cyc(40);
      check("b2b_events", vld_events - ev0, 2);
      check("b2b_vld_cycles", vld_hi - vh0, 2);
      check("b2b_busy_rises", busy_rises - br0, 2);
      check("b2b_errors", (fe_cnt - fe0) + (ov_cnt - ov0), 0);

      // Two-cycle glitch at prescale 2: busy for exactly the half-bit, then dropped.
      prescale = 16'd2;
      snap();
      rxd = 1'b0;
      wait_cyc(2);
      rxd = 1'b1;
      wait_cyc(30);
      check("glitch_events", vld_events - ev0, 0);
      check("glitch_busy_cycles", busy_hi - bh0, 8);
      check("glitch_errors", (fe_cnt - fe0) + (ov_cnt - ov0), 0);

      // prescale 0 ignores the line.
      prescale = 16'd0;
      snap();
      rxd = 1'b0;
      wait_cyc(40);
      rxd = 1'b1;
      wait_cyc(5);
      check("p0_busy_cycles", busy_hi - bh0, 0);
      prescale = 16'd2;

      // 0x3C with a low stop bit: frame error, then held busy until the line is released.
      snap();
      send_frame(8'h3C, 16, 1'b0);
      wait_cyc(20);
      check("fe_busy_held", {31'd0, busy}, 32'd1);
      check("fe_pulse_cycles", fe_cnt - fe0, 1);
      rxd = 1'b1;
      wait_cyc(6);
      check("fe_busy_released", {31'd0, busy}, 32'd0);
      check("fe_events", vld_events - ev0, 0);
      check("fe_tvalid", {31'd0, axis.m_axis_tvalid}, 32'd0);

      // Overrun: tready low across two frames.
      axis.m_axis_tready = 1'b0;
      snap();
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h22);
      send_frame(8'h11, 16, 1'b1);
      send_frame(8'h22, 16, 1'b1);
      wait_cyc(10);
      check("ov_pulse_cycles", ov_cnt - ov0, 1);
      check("ov_events", vld_events - ev0, 2);
      check("ov_tvalid_held", {31'd0, axis.m_axis_tvalid}, 32'd1);
      check("ov_tdata", {24'd0, axis.m_axis_tdata}, 32'h22);
      axis.m_axis_tready = 1'b1;
      wait_cyc(2);
      check("ov_tvalid_cleared", {31'd0, axis.m_axis_tvalid}, 32'd0);

      // Reset during bit 4 of 0xFF abandons the frame; 0x81 afterwards is clean.
      snap();
      fork
         send_frame(8'hFF, 16, 1'b1);
         begin
            wait_cyc(16 * 5 + 8);
            rst = 1'b1;
            wait_cyc(1);
            check("midrst_busy", {31'd0, busy}, 32'd0);
            check("midrst_tvalid", {31'd0, axis.m_axis_tvalid}, 32'd0);
            check("midrst_tdata", {24'd0, axis.m_axis_tdata}, 32'd0);
            check("midrst_errs", {30'd0, overrun_error, frame_error}, 32'd0);
            rst = 1'b0;
         end
      join
      wait_cyc(20);
      check("midrst_no_output", vld_events - ev0, 0);
      check("midrst_no_errors", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
      exp_q.push_back(8'h81);
      send_frame(8'h81, 16, 1'b1);
      wait_cyc(20);
      check("post_rst_events", vld_events - ev0, 1);

      check("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
